// File: rtl/mc_rsp_pack_pkg.sv
// Shared packet layout, message types and FSM state type for the MC read-response packer.
package mc_rsp_pack_pkg;

  // NoC packet width used when the top is not given an explicit width.
  localparam int IO_WIDTH         = 80;

  // Packet field layout, LSB first.
  localparam int NODE_W           = 4;
  localparam int PKT_TYPE_LSB     = 0;
  localparam int PKT_TYPE_W       = 4;
  localparam int SENDOKBIT_OFFSET = 4;
  localparam int PKT_SRC_LSB      = 5;
  localparam int PKT_DST_LSB      = 9;
  localparam int PKT_ADDR_LSB     = 13;
  localparam int PKT_ADDR_W       = 32;
  localparam int PKT_DATA_LSB     = 45;
  localparam int PKT_DATA_W       = 32;

  localparam logic [PKT_TYPE_W-1:0] TYPE_READ  = 4'h1;
  localparam logic [PKT_TYPE_W-1:0] TYPE_REPLY = 4'h2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/mc_rsp_pack_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle; otherwise
// it is dropped and reported on the ovf strobe.
module mc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign ovf      = push && !push_ok;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
    if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mc_rsp_pack.sv
// Read-response packer: pairs queued read headers with returned read words in issue order
// and emits one reply packet per read toward the NoC injection port.
//
// state   | meaning
// --------+--------------------------------------------------
// ST_IDLE | output register empty, pkt_out_valid low
// ST_HOLD | reply held on pkt_out, waiting for pkt_out_ready
module mc_rsp_pack
  import mc_rsp_pack_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = IO_WIDTH,
  parameter int MC_NODE_ID      = 0,
  parameter int DEPTH           = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FIFO_DATA_WIDTH-1:0] out_addr_data,
  input  logic                       out_addr_valid,
  input  logic                       rd_data_valid,
  input  logic [31:0]                rd_data_fifo_out,
  output logic [FIFO_DATA_WIDTH-1:0] pkt_out,
  output logic                       pkt_out_valid,
  input  logic                       pkt_out_ready,
  output logic [$clog2(DEPTH):0]     hdr_level,
  output logic [31:0]                rsp_count,
  output logic                       ovf_err
);

  rsp_state_e                 state_q, state_d;
  logic [FIFO_DATA_WIDTH-1:0] pkt_q, pkt_d;
  logic [31:0]                rsp_count_q, rsp_count_d;
  logic                       ovf_q, ovf_d;

  logic [FIFO_DATA_WIDTH-1:0] hdr_data;
  logic                       hdr_full, hdr_empty, hdr_ovf;
  logic [31:0]                dat_word;
  logic                       dat_full, dat_empty, dat_ovf;
  logic [$clog2(DEPTH):0]     dat_level_unused;
  logic                       pack;
  logic                       accept;
  logic [FIFO_DATA_WIDTH-1:0] reply;

  // The output register counts as free when it is empty or being drained this cycle.
  assign accept = (state_q == ST_HOLD) && pkt_out_ready;
  assign pack   = !hdr_empty && !dat_empty && ((state_q == ST_IDLE) || pkt_out_ready);

  mc_sync_fifo #(
    .WIDTH (FIFO_DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_hdr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_addr_valid),
    .push_data (out_addr_data),
    .pop       (pack),
    .pop_data  (hdr_data),
    .full      (hdr_full),
    .empty     (hdr_empty),
    .count     (hdr_level),
    .ovf       (hdr_ovf)
  );

  mc_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_dat_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_data_valid),
    .push_data (rd_data_fifo_out),
    .pop       (pack),
    .pop_data  (dat_word),
    .full      (dat_full),
    .empty     (dat_empty),
    .count     (dat_level_unused),
    .ovf       (dat_ovf)
  );

  // Reply assembly from the head header and head word; every bit not named here stays zero.
  always_comb begin
    reply = '0;
    reply[PKT_TYPE_LSB +: PKT_TYPE_W] = TYPE_REPLY;
    reply[SENDOKBIT_OFFSET]           = 1'b1;
    reply[PKT_DST_LSB +: NODE_W]      = hdr_data[PKT_SRC_LSB +: NODE_W];
    reply[PKT_SRC_LSB +: NODE_W]      = NODE_W'(MC_NODE_ID);
    reply[PKT_ADDR_LSB +: PKT_ADDR_W] = hdr_data[PKT_ADDR_LSB +: PKT_ADDR_W];
    reply[PKT_DATA_LSB +: PKT_DATA_W] = dat_word;
  end

  // Next-state, output-register, counter and sticky-error logic.
  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    rsp_count_d = rsp_count_q;
    ovf_d       = ovf_q | hdr_ovf | dat_ovf;
    if (accept) rsp_count_d = rsp_count_q + 32'd1;
    if (pack) begin
      state_d = ST_HOLD;
      pkt_d   = reply;
    end else if (accept) begin
      state_d = ST_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pkt_q       <= '0;
      rsp_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      rsp_count_q <= rsp_count_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pkt_out       = pkt_q;
  assign pkt_out_valid = (state_q == ST_HOLD);
  assign rsp_count     = rsp_count_q;
  assign ovf_err       = ovf_q;

  // Full flags only feed the overflow decision inside the FIFOs; keep them observable.
  logic full_unused;
  assign full_unused = hdr_full | dat_full;

endmodule

// File: tb/tb_mc_rsp_pack.sv
module tb_mc_rsp_pack;
  import mc_rsp_pack_pkg::*;

  localparam int W     = IO_WIDTH;
  localparam int DEPTH = 16;
  localparam int NODE  = 5;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  out_addr_data;
  logic          out_addr_valid;
  logic          rd_data_valid;
  logic [31:0]   rd_data_fifo_out;
  logic [W-1:0]  pkt_out;
  logic          pkt_out_valid;
  logic          pkt_out_ready;
  logic [LW-1:0] hdr_level;
  logic [31:0]   rsp_count;
  logic          ovf_err;

  mc_rsp_pack #(
    .FIFO_DATA_WIDTH (W),
    .MC_NODE_ID      (NODE),
    .DEPTH           (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .out_addr_data    (out_addr_data),
    .out_addr_valid   (out_addr_valid),
    .rd_data_valid    (rd_data_valid),
    .rd_data_fifo_out (rd_data_fifo_out),
    .pkt_out          (pkt_out),
    .pkt_out_valid    (pkt_out_valid),
    .pkt_out_ready    (pkt_out_ready),
    .hdr_level        (hdr_level),
    .rsp_count        (rsp_count),
    .ovf_err          (ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: reads in issue order, words in return order, paired replies expected.
  logic [W-1:0] mh[$];
  logic [31:0]  md[$];
  logic [W-1:0] exp_q[$];
  int           acc_cnt = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk_hdr(input int src, input logic [31:0] addr);
    logic [W-1:0] h;
    h = W'({$urandom(), $urandom(), $urandom()});
    h[PKT_TYPE_LSB +: PKT_TYPE_W] = TYPE_READ;
    h[PKT_SRC_LSB +: NODE_W]      = NODE_W'(src);
    h[PKT_ADDR_LSB +: PKT_ADDR_W] = addr;
    return h;
  endfunction

  function automatic logic [W-1:0] mk_reply(input logic [W-1:0] h, input logic [31:0] w);
    logic [W-1:0] r;
    r = '0;
    r[PKT_TYPE_LSB +: PKT_TYPE_W] = TYPE_REPLY;
    r[SENDOKBIT_OFFSET]           = 1'b1;
    r[PKT_DST_LSB +: NODE_W]      = h[PKT_SRC_LSB +: NODE_W];
    r[PKT_SRC_LSB +: NODE_W]      = NODE_W'(NODE);
    r[PKT_ADDR_LSB +: PKT_ADDR_W] = h[PKT_ADDR_LSB +: PKT_ADDR_W];
    r[PKT_DATA_LSB +: PKT_DATA_W] = w;
    return r;
  endfunction

  task automatic model_pair();
    while (mh.size() > 0 && md.size() > 0)
      exp_q.push_back(mk_reply(mh.pop_front(), md.pop_front()));
  endtask

  // Drives one cycle of strobes; called and returns at posedge + 1.
  task automatic drive(input bit hv, input logic [W-1:0] h, input bit keep_h,
                       input bit dv, input logic [31:0] w);
    out_addr_valid   = hv;
    out_addr_data    = h;
    rd_data_valid    = dv;
    rd_data_fifo_out = w;
    @(posedge clk);
    #1;
    out_addr_valid = 1'b0;
    rd_data_valid  = 1'b0;
    if (dv) md.push_back(w);
    if (hv && keep_h) mh.push_back(h);
    model_pair();
  endtask

  task automatic send_hdr(input logic [W-1:0] h, input bit keep);
    drive(1'b1, h, keep, 1'b0, 32'd0);
  endtask

  task automatic send_dat(input logic [31:0] w);
    drive(1'b0, '0, 1'b0, 1'b1, w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reply must appear exactly two edges after the last strobe edge.
  task automatic lat_check(input string nm);
    @(negedge clk);
    check({nm, "_lat_early"}, W'(pkt_out_valid), W'(1'b0));
    @(negedge clk);
    check({nm, "_lat_valid"}, W'(pkt_out_valid), W'(1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      idle(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d replies still expected, required 0", nm, exp_q.size());
    end
    idle(2);
  endtask

  // Monitor: checks every accepted reply against the scoreboard and held replies for stability.
  logic [W-1:0] prev_pkt;
  bit           hold_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("rsp_count", W'(rsp_count), W'(acc_cnt));
      if (hold_prev) begin
        check("hold_valid", W'(pkt_out_valid), W'(1'b1));
        check("hold_stable", pkt_out, prev_pkt);
      end
      if (pkt_out_valid && pkt_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_reply: got %h required none", pkt_out);
        end else begin
          check("reply", pkt_out, exp_q.pop_front());
        end
        acc_cnt++;
      end
      hold_prev = pkt_out_valid && !pkt_out_ready;
      prev_pkt  = pkt_out;
    end
  end

  initial begin
    int hdr_tot, dat_tot, acc0;
    bit hv, dv;
    logic [W-1:0] h;

    rst_n            = 1'b0;
    out_addr_data    = '0;
    out_addr_valid   = 1'b0;
    rd_data_valid    = 1'b0;
    rd_data_fifo_out = '0;
    pkt_out_ready    = 1'b0;
    #1;
    check("rst_valid", W'(pkt_out_valid), W'(1'b0));
    check("rst_pkt", pkt_out, '0);
    check("rst_count", W'(rsp_count), '0);
    check("rst_ovf", W'(ovf_err), '0);
    check("rst_level", W'(hdr_level), '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Single read
    pkt_out_ready = 1'b1;
    send_hdr(mk_hdr(3, 32'h100), 1'b1);
    idle(3);
    send_dat(32'hDEADBEEF);
    lat_check("single");
    idle(2);
    check("single_count", W'(rsp_count), W'(32'd1));

    // Data before header
    send_dat(32'h5);
    idle(2);
    send_hdr(mk_hdr(1, 32'h2000), 1'b1);
    lat_check("dbh");
    idle(2);
    check("dbh_ovf", W'(ovf_err), W'(1'b0));

    // Backpressure
    pkt_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_hdr(mk_hdr(i + 2, 32'h40 * i), 1'b1);
    for (int i = 0; i < 4; i++) send_dat($urandom());
    idle(10);
    pkt_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_burst_valid", W'(pkt_out_valid), W'(1'b1));
    end
    @(negedge clk);
    check("bp_done_valid", W'(pkt_out_valid), W'(1'b0));
    check("bp_count", W'(rsp_count), W'(32'd6));
    @(posedge clk);
    #1;

    // Randomized traffic without overflow
    hdr_tot = 0;
    dat_tot = 0;
    acc0    = acc_cnt;
    for (int c = 0; c < 800; c++) begin
      hv = ($urandom_range(2) == 0) && (hdr_tot - (acc_cnt - acc0) < DEPTH - 1);
      dv = ($urandom_range(2) == 0) && (dat_tot - (acc_cnt - acc0) < DEPTH - 1);
      pkt_out_ready = ($urandom_range(3) != 0);
      h = mk_hdr($urandom_range(15), $urandom());
      drive(hv, h, 1'b1, dv, $urandom());
      if (hv) hdr_tot++;
      if (dv) dat_tot++;
    end
    pkt_out_ready = 1'b1;
    idle(40);
    while (hdr_tot > dat_tot) begin
      send_dat($urandom());
      dat_tot++;
      idle(1);
    end
    while (dat_tot > hdr_tot) begin
      send_hdr(mk_hdr($urandom_range(15), $urandom()), 1'b1);
      hdr_tot++;
      idle(1);
    end
    drain("random");
    check("random_level", W'(hdr_level), '0);
    check("random_ovf", W'(ovf_err), '0);

    // Reset mid-operation: one reply held, three headers queued
    pkt_out_ready = 1'b0;
    send_hdr(mk_hdr(7, 32'h700), 1'b1);
    send_dat(32'h1234);
    for (int i = 0; i < 3; i++) send_hdr(mk_hdr(i, 32'h800 + i), 1'b1);
    idle(2);
    check("pre_rst_valid", W'(pkt_out_valid), W'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", W'(pkt_out_valid), W'(1'b0));
    check("midrst_level", W'(hdr_level), '0);
    check("midrst_count", W'(rsp_count), '0);
    @(negedge clk);
    mh.delete();
    md.delete();
    exp_q.delete();
    acc_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pkt_out_ready = 1'b1;
    idle(20);
    check("postrst_valid", W'(pkt_out_valid), W'(1'b0));
    check("postrst_count", W'(rsp_count), '0);

    // Push on full header FIFO coinciding with a pack
    for (int i = 0; i < DEPTH; i++) send_hdr(mk_hdr(i % 16, 32'h1000 + i), 1'b1);
    @(negedge clk);
    check("pof_full_level", W'(hdr_level), W'(DEPTH));
    @(posedge clk);
    #1;
    send_dat(32'hCAFE0000);
    send_hdr(mk_hdr(9, 32'h9999), 1'b1);
    @(negedge clk);
    check("pof_level", W'(hdr_level), W'(DEPTH));
    check("pof_ovf", W'(ovf_err), W'(1'b0));
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) send_dat(32'hCAFE0001 + i);
    drain("pof");
    check("pof_end_level", W'(hdr_level), '0);
    check("pof_end_ovf", W'(ovf_err), W'(1'b0));

    // Overflow: DEPTH+1 headers, last one dropped
    for (int i = 0; i < DEPTH + 1; i++) send_hdr(mk_hdr(15 - (i % 16), 32'h3000 + i), i < DEPTH);
    @(negedge clk);
    check("ovf_level", W'(hdr_level), W'(DEPTH));
    check("ovf_flag", W'(ovf_err), W'(1'b1));
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) send_dat(32'hB000 + i);
    drain("ovf");
    check("ovf_end_level", W'(hdr_level), '0);
    check("ovf_sticky", W'(ovf_err), W'(1'b1));
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_rsp_pack.md
# mc_rsp_pack

Read-response packer for the memory-controller port of the NoC. It queues the request header of every memory read the MC issues, plus every read word returned by memory. It pairs them in order and emits one NoC reply packet per read, addressed back to the requesting core. It sits directly downstream of the MC request stage and upstream of the NoC injection port.

## Interface
Parameters:
- `FIFO_DATA_WIDTH`, default `` `IO_WIDTH ``, NoC packet width.
- `MC_NODE_ID`, default 0, node id written into the source field of replies.
- `DEPTH`, default 16, entries in each internal FIFO; must be a power of two ≥ 2.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `out_addr_data`, in, `FIFO_DATA_WIDTH`: request packet of an issued memory read.
- `out_addr_valid`, in, 1: one-cycle strobe; capture `out_addr_data`.
- `rd_data_valid`, in, 1: one-cycle strobe; a read word is present. No backpressure exists on this input.
- `rd_data_fifo_out`, in, 32: read word.
- `pkt_out`, out, `FIFO_DATA_WIDTH`: reply packet.
- `pkt_out_valid`, out, 1: `pkt_out` is valid.
- `pkt_out_ready`, in, 1: NoC accepts the packet.
- `hdr_level`, out, `$clog2(DEPTH)+1`: header FIFO occupancy.
- `rsp_count`, out, 32: number of replies accepted by the NoC.
- `ovf_err`, out, 1: sticky; a strobe arrived while its FIFO was full.

## Operation
- Header FIFO:
  - Pushed on `out_addr_valid`.
  - Stores the whole packet.
- Data FIFO:
  - Pushed on `rd_data_valid`.
  - Stores the 32-bit word.
- Both FIFOs are in-order; memory returns reads in issue order, so the k-th word pairs with the k-th header.
- Data may arrive before its header. It waits in the data FIFO and is not an error.
- Pack condition: both FIFOs non-empty AND the output register is free (`!pkt_out_valid`, or `pkt_out_ready` in the same cycle). When it holds:
  - Pop both FIFOs.
  - Load the output register.
- Reply fields:
  - `PKT_TYPE` = `TYPE_REPLY`.
  - `PKT_DST` = header `PKT_SRC`.
  - `PKT_SRC` = `MC_NODE_ID`.
  - `PKT_ADDR` = header `PKT_ADDR`, unshifted byte address.
  - `PKT_DATA` = the word.
  - `SENDOKBIT` = 1.
  - All other bits are 0.
- Output handshake:
  - `pkt_out_valid` stays high and `pkt_out` stays stable until the cycle `pkt_out_valid && pkt_out_ready`.
  - In that cycle `rsp_count` increments by 1 and wraps at 2^32.
- States:
  - IDLE: output empty.
  - HOLD: output valid and waiting for `pkt_out_ready`.
  - IDLE→HOLD: on pack.
  - HOLD→IDLE: on accept with no pack.
  - HOLD→HOLD: on accept with a simultaneous pack. Back-to-back replies at one per cycle are allowed.
- Full FIFO on push:
  - If a pop happens in the same cycle, the push is accepted and occupancy is unchanged.
  - Otherwise the strobe is dropped and `ovf_err` is set.
  - `ovf_err` clears only on reset.
- Empty FIFOs: no pop and no output change.
- Simultaneous push and pop on either FIFO: occupancy is unchanged and data ordering is preserved.

## Timing
- Reset values, applied immediately on `rst_n` low regardless of `clk`:
  - `pkt_out_valid` = 0.
  - `pkt_out` = 0.
  - `rsp_count` = 0.
  - `ovf_err` = 0.
  - `hdr_level` = 0.
  - FIFO pointers = 0.
- Reset mid-operation discards all queued headers, queued words and any held reply. Nothing is emitted after deassertion until new strobes arrive.
- FIFO write happens at the capturing edge; the entry is visible as non-empty in the next cycle.
- Latency, with the header already queued and the output free:
  - `rd_data_valid` sampled at edge E.
  - `pkt_out_valid` high after edge E+1 (2 cycles).
- Throughput is one reply per cycle while `pkt_out_ready` is held high.
- `hdr_level` is registered and reflects pushes and pops of the previous edge.

## Structure
- Add `TYPE_REPLY`, `PKT_DST` and `SENDOKBIT_OFFSET` usage to `noc_pkt.vh`, alongside the existing field macros. No new field widths are introduced.
- Sub-module `mc_sync_fifo`, parameterised by width and `DEPTH`:
  - Single clock, async active-low reset.
  - Outputs: registered count, `full`, `empty`, first-word-fall-through read data.
  - Instantiated twice: header FIFO of `FIFO_DATA_WIDTH` bits and data FIFO of 32 bits.
- The top level holds the pack logic, output register, counters and error flag.

## Test plan
- Single read:
  - Stimulus: header with src=3, addr=0x100, then 4 cycles later word 0xDEADBEEF; `pkt_out_ready` = 1.
  - Response: one reply with dst=3, src=`MC_NODE_ID`, addr=0x100, data=0xDEADBEEF, 2 cycles after the data strobe; `rsp_count` = 1.
- Data before header:
  - Stimulus: word 0x5 arrives 3 cycles before the header from src=1.
  - Response: reply emitted 2 cycles after the header strobe with data=0x5; `ovf_err` = 0.
- Backpressure:
  - Stimulus: 4 reads queued; `pkt_out_ready` = 0 for 10 cycles, then 1.
  - Response: first reply held stable for all 10 cycles, then 4 replies on consecutive cycles in issue order; `rsp_count` = 4.
- Overflow:
  - Stimulus: `DEPTH`+1 header strobes with no data.
  - Response: `hdr_level` = `DEPTH` and `ovf_err` = 1. After `DEPTH` words arrive, exactly `DEPTH` replies are emitted, for the first `DEPTH` headers.
- Push on full with pop:
  - Stimulus: header FIFO full; a header strobe coincides with a pack.
  - Response: header accepted, `hdr_level` unchanged, `ovf_err` = 0.
- Reset mid-operation:
  - Stimulus: `rst_n` pulsed low asynchronously while a reply is held and 3 headers are queued.
  - Response: `pkt_out_valid` falls immediately; `hdr_level` = 0 and `rsp_count` = 0; no reply appears after release.
